softmax_prob_sink: RTL and testbench

- Receiving end of the softmax output stream (out_valid_o/out_data_o/done_o).
- That stream has no backpressure and runs at one element per cycle. This block captures one full row of Q1.15 probabilities into a block-RAM buffer and accumulates their sum for sanity checking.
- It then replays the row over a valid/ready stream to the downstream attention-value stage, absorbing any downstream stalls.
- It also tells the attention controller when it is safe to launch the next softmax run.

---
 rtl/softmax_pkg.sv | 14 +
 rtl/prob_buf_ram.sv | 31 +++
 rtl/softmax_prob_sink.sv | 179 +++++++++++++++++
 tb/tb_softmax_prob_sink.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Definitions shared by the softmax engine and its probability sink.
// Covers the FSM state encoding and the Q1.15 probability format.
package softmax_pkg;

    localparam int unsigned PROB_W = 16;
    localparam logic [PROB_W-1:0] PROB_ONE = 16'd32768;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/prob_buf_ram.sv
// Simple dual-port row buffer: one write port and one read port.
// The read data is registered, so it appears one cycle after re_i.
module prob_buf_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/softmax_prob_sink.sv
// Captures one softmax row into a buffer and sums it.
// Then replays the row over a valid/ready stream that tolerates backpressure.
module softmax_prob_sink
    import softmax_pkg::*;
#(
    parameter int unsigned N      = 256,
    parameter int unsigned DATA_W = PROB_W,
    parameter int unsigned SUM_W  = 24,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    output logic              ready_o,
    input  logic              sm_valid_i,
    input  logic [DATA_W-1:0] sm_data_i,
    input  logic              sm_done_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic [IDX_W-1:0]  m_index_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [SUM_W-1:0]  prob_sum_o,
    output logic              sum_valid_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

    state_t r_state, w_state_d;

    logic [CNT_W-1:0]  r_wcnt, r_rcnt;
    logic [SUM_W-1:0]  r_sum;
    logic              r_sum_valid, r_err;
    logic              r_rd_pend;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [IDX_W-1:0]  r_skid_idx;
    logic              r_m_valid, r_m_last;
    logic [DATA_W-1:0] r_m_data;
    logic [IDX_W-1:0]  r_m_index;

    logic              w_cap_ok, w_done, w_pop, w_out_free, w_issue;
    logic [CNT_W-1:0]  w_final_cnt;
    logic [1:0]        w_occ;
    logic              w_land_valid, w_land_last;
    logic [DATA_W-1:0] w_land_data, w_ram_rdata;
    logic [IDX_W-1:0]  w_land_idx;

    assign w_cap_ok    = (r_state == S_CAPTURE) && sm_valid_i && (r_wcnt != FULL);
    assign w_done      = (r_state == S_CAPTURE) && sm_done_i;
    assign w_final_cnt = r_wcnt + CNT_W'(w_cap_ok);

    assign w_pop      = r_m_valid && m_ready_i;
    assign w_out_free = !r_m_valid || m_ready_i;
    // Items held or in flight; a new read is issued only if a slot is guaranteed next cycle.
    assign w_occ   = 2'(r_m_valid) + 2'(r_skid_valid) + 2'(r_rd_pend);
    assign w_issue = (r_state == S_DRAIN) && (r_rcnt != r_wcnt) && ((w_occ - 2'(w_pop)) <= 2'd1);

    assign w_land_valid = r_skid_valid || r_rd_pend;
    assign w_land_data  = r_skid_valid ? r_skid_data : w_ram_rdata;
    assign w_land_idx   = r_skid_valid ? r_skid_idx : r_rd_idx;
    assign w_land_last  = ({1'b0, w_land_idx} == (r_wcnt - 1'b1));

    prob_buf_ram #(
        .DEPTH (N),
        .WIDTH (DATA_W)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (w_cap_ok),
        .waddr_i (r_wcnt[IDX_W-1:0]),
        .wdata_i (sm_data_i),
        .re_i    (w_issue),
        .raddr_i (r_rcnt[IDX_W-1:0]),
        .rdata_o (w_ram_rdata)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE:    if (arm_i) w_state_d = S_CAPTURE;
            S_CAPTURE: if (sm_done_i) w_state_d = (w_final_cnt == '0) ? S_IDLE : S_DRAIN;
            S_DRAIN:   if (w_pop && r_m_last) w_state_d = S_IDLE;
            default:   w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_idx     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_idx   <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
            r_m_index    <= '0;
        end else begin
            r_sum_valid <= w_done;
            if ((r_state == S_IDLE) && arm_i) begin
                r_wcnt <= '0;
                r_sum  <= '0;
                r_err  <= 1'b0;
            end
            if (w_cap_ok) begin
                r_wcnt <= r_wcnt + 1'b1;
                r_sum  <= r_sum + SUM_W'(sm_data_i);
            end
            if (sm_valid_i && ((r_state != S_CAPTURE) || (r_wcnt == FULL))) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                if (w_final_cnt != FULL) r_err <= 1'b1;
                r_rcnt       <= '0;
                r_rd_pend    <= 1'b0;
                r_skid_valid <= 1'b0;
                r_m_valid    <= 1'b0;
                r_m_last     <= 1'b0;
            end
            if (r_state == S_DRAIN) begin
                r_rd_pend <= w_issue;
                if (w_issue) begin
                    r_rcnt   <= r_rcnt + 1'b1;
                    r_rd_idx <= r_rcnt[IDX_W-1:0];
                end
                if (w_out_free) begin
                    // Skid drains first; a read landing behind it takes its place.
                    r_m_valid    <= w_land_valid;
                    r_m_last     <= w_land_valid && w_land_last;
                    if (w_land_valid) begin
                        r_m_data  <= w_land_data;
                        r_m_index <= w_land_idx;
                    end
                    r_skid_valid <= r_skid_valid && r_rd_pend;
                    if (r_skid_valid) begin
                        r_skid_data <= w_ram_rdata;
                        r_skid_idx  <= r_rd_idx;
                    end
                end else if (r_rd_pend) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_ram_rdata;
                    r_skid_idx   <= r_rd_idx;
                end
                if (w_pop && r_m_last) begin
                    r_m_valid    <= 1'b0;
                    r_m_last     <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_rd_pend    <= 1'b0;
                end
            end
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign m_valid_o   = r_m_valid;
    assign m_data_o    = r_m_data;
    assign m_index_o   = r_m_index;
    assign m_last_o    = r_m_last;
    assign prob_sum_o  = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign err_o       = r_err;

endmodule

// File: tb/tb_softmax_prob_sink.sv
// Self-checking bench for softmax_prob_sink: randomised rows and downstream stalls.
// Results are checked against a queue-based model of what the row should be.
module tb_softmax_prob_sink;

    localparam int N  = 256;
    localparam int DW = 16;
    localparam int SW = 24;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          sm_valid = 1'b0;
    logic [DW-1:0] sm_data = '0;
    logic          sm_done = 1'b0;
    logic          m_ready = 1'b0;
    logic          ready_o, m_valid_o, m_last_o, sum_valid_o, err_o;
    logic [DW-1:0] m_data_o;
    logic [IW-1:0] m_index_o;
    logic [SW-1:0] prob_sum_o;

    always #5 clk = ~clk;

    softmax_prob_sink #(
        .N      (N),
        .DATA_W (DW),
        .SUM_W  (SW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .arm_i       (arm),
        .ready_o     (ready_o),
        .sm_valid_i  (sm_valid),
        .sm_data_i   (sm_data),
        .sm_done_i   (sm_done),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_index_o   (m_index_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready),
        .prob_sum_o  (prob_sum_o),
        .sum_valid_o (sum_valid_o),
        .err_o       (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] exp_sum;
    logic          exp_err;
    logic [DW-1:0] rx_data[$];
    int            rx_idx[$];
    logic          rx_last[$];
    int            stall_bad;
    int            coll_cyc;

    // Model: only the first N elements fit; the row is in error unless exactly N arrive.
    function automatic void build_exp();
        exp_q.delete();
        exp_sum = '0;
        for (int i = 0; i < tx_q.size() && i < N; i++) begin
            exp_q.push_back(tx_q[i]);
            exp_sum = exp_sum + SW'(tx_q[i]);
        end
        exp_err = (tx_q.size() != N);
    endfunction

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic stream_row();
        if (tx_q.size() == 0) begin
            sm_done = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < tx_q.size(); i++) begin
            sm_valid = 1'b1;
            sm_data  = tx_q[i];
            sm_done  = (i == tx_q.size() - 1);
            @(negedge clk);
        end
        sm_valid = 1'b0;
        sm_done  = 1'b0;
    endtask

    task automatic fill_random(input int len);
        tx_q.delete();
        for (int i = 0; i < len; i++) tx_q.push_back(DW'($urandom_range(0, 65535)));
    endtask

    // Records every handshake; mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic collect(input int mode, input int stop_idx);
        logic [DW-1:0] pd;
        logic [IW-1:0] pi;
        logic          pl;
        bit            prev_stall, hs, hs_last;
        int            hs_idx;
        rx_data.delete();
        rx_idx.delete();
        rx_last.delete();
        stall_bad  = 0;
        coll_cyc   = 0;
        prev_stall = 0;
        pd = '0;
        pi = '0;
        pl = 1'b0;
        forever begin
            if (coll_cyc >= 4 * N + 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL collect_timeout: got %0d elements, required a completed row",
                         rx_data.size());
                break;
            end
            if (prev_stall && (m_valid_o !== 1'b1 || m_data_o !== pd || m_index_o !== pi ||
                               m_last_o !== pl)) stall_bad++;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (coll_cyc % 4 == 0) || (coll_cyc % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            hs      = (m_valid_o === 1'b1) && m_ready;
            hs_last = (m_last_o === 1'b1);
            hs_idx  = int'(m_index_o);
            if (hs) begin
                rx_data.push_back(m_data_o);
                rx_idx.push_back(hs_idx);
                rx_last.push_back(m_last_o);
            end
            prev_stall = (m_valid_o === 1'b1) && !m_ready;
            pd = m_data_o;
            pi = m_index_o;
            pl = m_last_o;
            @(negedge clk);
            coll_cyc++;
            if (hs && (hs_last || hs_idx == stop_idx)) break;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({ready_o, m_valid_o, m_last_o, sum_valid_o, err_o} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/val/last/sv/err=%b%b%b%b%b, required 10000",
                     ready_o, m_valid_o, m_last_o, sum_valid_o, err_o);
        end
        n_cmp++;
        if (m_data_o !== '0 || m_index_o !== '0 || prob_sum_o !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got data=%0h idx=%0d sum=%0h, required 0 0 0",
                     m_data_o, m_index_o, prob_sum_o);
        end
    endtask

    task automatic test_nominal(input string name);
        tx_q.delete();
        for (int i = 0; i < N; i++) tx_q.push_back(16'd128);
        build_exp();
        arm_pulse();
        stream_row();
        n_cmp++;
        if (sum_valid_o !== 1'b1 || prob_sum_o !== 24'd32768 || err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_sum: got sv=%b sum=%0d err=%b, required 1 32768 0",
                     name, sum_valid_o, prob_sum_o, err_o);
        end
        collect(0, -1);
        n_cmp++;
        if (rx_data.size() != N || coll_cyc != N + 2) begin
            n_bad++;
            $display("FAIL %s_count: got %0d elems in %0d cycles, required %0d in %0d",
                     name, rx_data.size(), coll_cyc, N, N + 2);
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_cmp++;
            if (rx_data[i] !== exp_q[i] || rx_idx[i] != i || rx_last[i] !== (i == N - 1)) begin
                n_bad++;
                $display("FAIL %s_elem %0d: got data=%0d idx=%0d last=%b, required %0d %0d %b",
                         name, i, rx_data[i], rx_idx[i], rx_last[i], exp_q[i], i, (i == N - 1));
            end
        end
        n_cmp++;
        if (ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_end: got ready=%b valid=%b, required 1 0", name, ready_o, m_valid_o);
        end
    endtask

    task automatic test_stall();
        tx_q.delete();
        for (int i = 0; i < N; i++) tx_q.push_back(DW'(i));
        build_exp();
        arm_pulse();
        stream_row();
        collect(1, -1);
        n_cmp++;
        if (rx_data.size() != N || stall_bad != 0) begin
            n_bad++;
            $display("FAIL stall_count: got %0d elems, %0d unstable stalls, required %0d and 0",
                     rx_data.size(), stall_bad, N);
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_cmp++;
            if (rx_data[i] !== exp_q[i] || rx_idx[i] != i) begin
                n_bad++;
                $display("FAIL stall_elem %0d: got data=%0d idx=%0d, required %0d %0d",
                         i, rx_data[i], rx_idx[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_length(input string name, input int len, input int mode);
        fill_random(len);
        build_exp();
        arm_pulse();
        stream_row();
        n_cmp++;
        if (sum_valid_o !== 1'b1 || prob_sum_o !== exp_sum || err_o !== exp_err) begin
            n_bad++;
            $display("FAIL %s_sum: got sv=%b sum=%0d err=%b, required 1 %0d %b",
                     name, sum_valid_o, prob_sum_o, err_o, exp_sum, exp_err);
        end
        collect(mode, -1);
        n_cmp++;
        if (rx_data.size() != exp_q.size() || stall_bad != 0 || ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_count: got %0d elems stalls_bad=%0d ready=%b, required %0d 0 1",
                     name, rx_data.size(), stall_bad, ready_o, exp_q.size());
        end
        for (int i = 0; i < rx_data.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_data[i] !== exp_q[i] || rx_idx[i] != (i % N) ||
                rx_last[i] !== (i == exp_q.size() - 1)) begin
                n_bad++;
                $display("FAIL %s_elem %0d: got data=%0d idx=%0d last=%b, required %0d %0d %b",
                         name, i, rx_data[i], rx_idx[i], rx_last[i], exp_q[i], i,
                         (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_empty();
        arm_pulse();
        sm_done = 1'b1;
        @(negedge clk);
        sm_done = 1'b0;
        n_cmp++;
        if (sum_valid_o !== 1'b1 || prob_sum_o !== '0 || err_o !== 1'b1 || ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_row: got sv=%b sum=%0d err=%b ready=%b, required 1 0 1 1",
                     sum_valid_o, prob_sum_o, err_o, ready_o);
        end
        @(negedge clk);
        n_cmp++;
        if (sum_valid_o !== 1'b0 || m_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_pulse: got sv=%b valid=%b, required 0 0", sum_valid_o, m_valid_o);
        end
    endtask

    task automatic test_stray();
        sm_valid = 1'b1;
        sm_data  = 16'hBEEF;
        @(negedge clk);
        sm_valid = 1'b0;
        n_cmp++;
        if (err_o !== 1'b1 || ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_idle: got err=%b ready=%b, required 1 1", err_o, ready_o);
        end
        arm_pulse();
        n_cmp++;
        if (err_o !== 1'b0 || ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_arm_clear: got err=%b ready=%b, required 0 0", err_o, ready_o);
        end
        fill_random(N);
        build_exp();
        stream_row();
        // Stray writes during replay must not reach the buffer being drained.
        fork
            collect(2, -1);
            begin
                repeat (5) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    sm_valid = 1'b1;
                    sm_data  = DW'($urandom_range(0, 65535));
                    @(negedge clk);
                end
                sm_valid = 1'b0;
            end
        join
        n_cmp++;
        if (err_o !== 1'b1 || rx_data.size() != N) begin
            n_bad++;
            $display("FAIL stray_drain: got err=%b elems=%0d, required 1 %0d",
                     err_o, rx_data.size(), N);
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_cmp++;
            if (rx_data[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stray_elem %0d: got %0d, required %0d", i, rx_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_random(N);
        arm_pulse();
        stream_row();
        collect(0, 50);
        n_cmp++;
        if (rx_data.size() != 51) begin
            n_bad++;
            $display("FAIL middrain_progress: got %0d elems, required 51", rx_data.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (m_valid_o !== 1'b0 || ready_o !== 1'b1 || err_o !== 1'b0 || prob_sum_o !== '0) begin
            n_bad++;
            $display("FAIL middrain_reset: got valid=%b ready=%b err=%b sum=%0d, required 0 1 0 0",
                     m_valid_o, ready_o, err_o, prob_sum_o);
        end
        test_nominal("after_reset");
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_stall();
        test_length("short", 100, 2);
        test_length("overrun", 260, 2);
        test_empty();
        test_stray();
        test_reset_mid_drain();
        test_length("single", 1, 0);
        test_length("random_len", int'($urandom_range(2, N - 1)), 2);
        test_length("random_full", N, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
